// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and memory-side signal bundle for dmem_arbiter
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 6
);
    logic                     p0_req;
    logic                     p0_we;
    logic [1:0]               p0_select;
    logic [ADDRESS_WIDTH-1:0] p0_addr;
    logic [DATA_WIDTH-1:0]    p0_wdata;
    logic                     p0_gnt;
    logic                     p0_valid;
    logic [DATA_WIDTH-1:0]    p0_rdata;
    logic                     p0_err;

    logic                     p1_req;
    logic                     p1_we;
    logic [1:0]               p1_select;
    logic [ADDRESS_WIDTH-1:0] p1_addr;
    logic [DATA_WIDTH-1:0]    p1_wdata;
    logic                     p1_gnt;
    logic                     p1_valid;
    logic [DATA_WIDTH-1:0]    p1_rdata;
    logic                     p1_err;

    logic [ADDRESS_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0]    mem_write_data;
    logic                     mem_memorywrite;
    logic                     mem_memoryread;
    logic [1:0]               mem_select;
    logic [DATA_WIDTH-1:0]    mem_read_data;
    logic                     mem_unalign;

    modport slave (
        input  p0_req, p0_we, p0_select, p0_addr, p0_wdata,
        output p0_gnt, p0_valid, p0_rdata, p0_err,
        input  p1_req, p1_we, p1_select, p1_addr, p1_wdata,
        output p1_gnt, p1_valid, p1_rdata, p1_err,
        output mem_address, mem_write_data, mem_memorywrite, mem_memoryread, mem_select,
        input  mem_read_data, mem_unalign
    );

    modport master (
        output p0_req, p0_we, p0_select, p0_addr, p0_wdata,
        input  p0_gnt, p0_valid, p0_rdata, p0_err,
        output p1_req, p1_we, p1_select, p1_addr, p1_wdata,
        input  p1_gnt, p1_valid, p1_rdata, p1_err,
        input  mem_address, mem_write_data, mem_memorywrite, mem_memoryread, mem_select,
        output mem_read_data, mem_unalign
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin data memory arbiter and access sequencer
module dmem_arbiter #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic                     last_winner_q, last_winner_d;
    logic                     win_q, win_d;
    logic                     we_q, we_d;
    logic [1:0]               sel_q, sel_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     mis_q, mis_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic                     err_q, err_d;

    logic                     any_req;
    logic                     pick;
    logic                     pick_we;
    logic [1:0]               pick_sel;
    logic [ADDRESS_WIDTH-1:0] pick_addr;
    logic [DATA_WIDTH-1:0]    pick_wdata;
    logic                     pick_mis;

    logic                     gnt0, gnt1, val0, val1;
    logic                     m_wr, m_rd;
    logic [ADDRESS_WIDTH-1:0] m_addr;
    logic [DATA_WIDTH-1:0]    m_wdata;
    logic [1:0]               m_sel;

    // Contention goes to the port that did not win last; a lone request always wins.
    always_comb begin
        any_req    = bus.p0_req | bus.p1_req;
        pick       = (bus.p0_req && bus.p1_req) ? ~last_winner_q : bus.p1_req;
        pick_we    = pick ? bus.p1_we     : bus.p0_we;
        pick_sel   = pick ? bus.p1_select : bus.p0_select;
        pick_addr  = pick ? bus.p1_addr   : bus.p0_addr;
        pick_wdata = pick ? bus.p1_wdata  : bus.p0_wdata;
        case (pick_sel)
            2'b00:   pick_mis = 1'b0;
            2'b01:   pick_mis = pick_addr[0];
            2'b10:   pick_mis = |pick_addr[1:0];
            default: pick_mis = |pick_addr[2:0];
        endcase
    end

    always_comb begin
        state_d       = state_q;
        last_winner_d = last_winner_q;
        win_d         = win_q;
        we_d          = we_q;
        sel_d         = sel_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        mis_d         = mis_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        gnt0          = 1'b0;
        gnt1          = 1'b0;
        val0          = 1'b0;
        val1          = 1'b0;
        m_wr          = 1'b0;
        m_rd          = 1'b0;
        m_addr        = '0;
        m_wdata       = '0;
        m_sel         = 2'b00;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    win_d         = pick;
                    last_winner_d = pick;
                    we_d          = pick_we;
                    sel_d         = pick_sel;
                    addr_d        = pick_addr;
                    wdata_d       = pick_wdata;
                    mis_d         = pick_mis;
                    state_d       = ACCESS;
                end
            end
            ACCESS: begin
                gnt0    = ~win_q;
                gnt1    = win_q;
                m_addr  = addr_q;
                m_sel   = sel_q;
                m_wdata = wdata_q;
                m_wr    = we_q & ~mis_q;
                m_rd    = ~we_q & ~mis_q;
                rdata_d = m_rd ? bus.mem_read_data : '0;
                err_d   = mis_q | (m_rd & bus.mem_unalign);
                state_d = RESP;
            end
            RESP: begin
                val0    = ~win_q;
                val1    = win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Gating on rst_n keeps a reset in ACCESS from committing a store.
        if (!rst_n) begin
            gnt0    = 1'b0;
            gnt1    = 1'b0;
            val0    = 1'b0;
            val1    = 1'b0;
            m_wr    = 1'b0;
            m_rd    = 1'b0;
            m_addr  = '0;
            m_wdata = '0;
            m_sel   = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_winner_q <= 1'b1;
            win_q         <= 1'b0;
            we_q          <= 1'b0;
            sel_q         <= 2'b00;
            addr_q        <= '0;
            wdata_q       <= '0;
            mis_q         <= 1'b0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_winner_q <= last_winner_d;
            win_q         <= win_d;
            we_q          <= we_d;
            sel_q         <= sel_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            mis_q         <= mis_d;
            rdata_q       <= rdata_d;
            err_q         <= err_d;
        end
    end

    assign bus.p0_gnt          = gnt0;
    assign bus.p1_gnt          = gnt1;
    assign bus.p0_valid        = val0;
    assign bus.p1_valid        = val1;
    assign bus.p0_rdata        = val0 ? rdata_q : '0;
    assign bus.p1_rdata        = val1 ? rdata_q : '0;
    assign bus.p0_err          = val0 & err_q;
    assign bus.p1_err          = val1 & err_q;
    assign bus.mem_address     = m_addr;
    assign bus.mem_write_data  = m_wdata;
    assign bus.mem_memorywrite = m_wr;
    assign bus.mem_memoryread  = m_rd;
    assign bus.mem_select      = m_sel;
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the byte-addressed data memory.
- Requester 0 is the core load/store unit; requester 1 is the loader/debug port.
- Performs round-robin arbitration, pre-checks natural alignment, drives one memory access per grant, and returns registered read data with an error flag.
- Sits between the core datapath and data_memory.

Parameters:
- DATA_WIDTH, 64, data path width, equal to the memory word width.
- ADDRESS_WIDTH, 6, byte address width of the memory.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- p0_req  in  1  requester 0 access request; held with its fields until p0_gnt.
- p0_we  in  1  1 = store, 0 = load.
- p0_select  in  2  size: 00 byte, 01 half, 10 word, 11 double.
- p0_addr  in  ADDRESS_WIDTH  byte address.
- p0_wdata  in  DATA_WIDTH  store data, LSB-aligned.
- p0_gnt  out  1  one-cycle pulse: request captured.
- p0_valid  out  1  one-cycle pulse: access complete.
- p0_rdata  out  DATA_WIDTH  load data, valid with p0_valid; 0 for stores and errors.
- p0_err  out  1  misaligned access, valid with p0_valid.
- p1_req, p1_we, p1_select, p1_addr, p1_wdata, p1_gnt, p1_valid, p1_rdata, p1_err: same directions, widths and meanings as the p0 set, for requester 1.
- mem_address  out  ADDRESS_WIDTH  to memory address.
- mem_write_data  out  DATA_WIDTH  to memory write_data.
- mem_memorywrite  out  1  to memory memorywrite.
- mem_memoryread  out  1  to memory memoryread.
- mem_select  out  2  to memory select.
- mem_read_data  in  DATA_WIDTH  memory read_data; combinational from address and select.
- mem_unalign  in  1  memory unalign flag.

Behaviour:
- Reset: rst_n low at a posedge puts the FSM in IDLE and forces every output to 0 (gnt, valid, err, rdata, mem_* strobes, address, data, select). last_winner resets to 1, so port 0 wins the first tie.
- FSM: IDLE -> ACCESS -> RESP -> IDLE. Every access takes exactly 3 cycles; at most one access is in flight.
- IDLE:
  - Requests are sampled only in IDLE.
  - One request pending: that port wins.
  - Both pending: the port other than last_winner wins.
  - At the posedge, latch the winner's we, select, addr and wdata into internal registers, update last_winner, and go to ACCESS.
  - No request: stay in IDLE; all outputs 0.
- Alignment pre-check, computed in IDLE on the winner's fields and latched as mis:
  - byte: always aligned.
  - half: fault if addr[0] != 0.
  - word: fault if addr[1:0] != 0.
  - double: fault if addr[2:0] != 0.
- ACCESS, one cycle:
  - Assert the winner's gnt.
  - mem_address, mem_select and mem_write_data come from the latched registers.
  - If mis = 0: mem_memorywrite = we, mem_memoryread = !we. If mis = 1: both strobes are 0.
  - The store commits in memory at the ACCESS-to-RESP edge.
  - On the same edge, rdata_q <= (read and !mis) ? mem_read_data : 0, and err_q <= mis | (mem_memoryread & mem_unalign).
- RESP, one cycle:
  - Assert the winner's valid with rdata_q and err_q; the loser's outputs stay 0.
  - Memory strobes are 0. Return to IDLE.
- Requester rule: drop req on the cycle after gnt. A req still high when the FSM returns to IDLE is a new request.
- Read data passes through unmodified; size and zero-extension are the memory's job.
- Simultaneous requests with last_winner = 0 grant port 1.
- Strict alternation under continuous contention; neither port waits more than one access.
- Reset during ACCESS: strobes are gated by rst_n, so no memory write occurs. The FSM goes to IDLE and no valid is issued.
- Reset during RESP: valid is suppressed.
- Address wrap-around is not handled here: aligned accesses never cross the top of memory.

Test Plan:
- Reset release, p0 load double addr 8 (memory image byte 8 = 0x02) -> p0_gnt in cycle 2, p0_valid in cycle 3, p0_rdata = 0x2, p0_err = 0.
- p1 store word 0xDEADBEEF at addr 16, then p1 load word addr 16 -> second p1_valid has rdata = 0xDEADBEEF; a load double at 16 returns 0xDEADBEEF.
- p0 and p1 both request continuously for 4 accesses from reset -> grant order 0,1,0,1; each valid pulse goes only to its own port.
- p0 store half at addr 3 -> mem_memorywrite never asserted; p0_valid with p0_err = 1, p0_rdata = 0; memory byte 3 unchanged.
- p1 load word addr 6 and load byte addr 7 -> first gives err = 1 and rdata = 0; second gives err = 0.
- p0 store byte 0xAA at addr 0 with rst_n low during ACCESS -> no write (byte 0 still 0x01), no p0_valid, FSM in IDLE next cycle.
